// File: rtl/sha256_padder_if.sv
// Message-word and padded-block handshake bundle for sha256_padder.
// The padder is the slave; the producer/consumer side is the master.
interface sha256_padder_if;
    logic         iMsgValid;
    logic         oMsgReady;
    logic [31:0]  iMsgData;
    logic         iMsgLast;
    logic [2:0]   iMsgBytes;
    logic [511:0] oBlock;
    logic         oBlockValid;
    logic         iBlockReady;
    logic         oLastBlock;

    modport master (
        output iMsgValid, iMsgData, iMsgLast, iMsgBytes, iBlockReady,
        input  oMsgReady, oBlock, oBlockValid, oLastBlock
    );

    modport slave (
        input  iMsgValid, iMsgData, iMsgLast, iMsgBytes, iBlockReady,
        output oMsgReady, oBlock, oBlockValid, oLastBlock
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit length.
module sha256_padder (
    input logic            iClk,
    input logic            iReset_n,
    sha256_padder_if.slave bus
);
    typedef enum logic [1:0] {S_FILL, S_OUT, S_EXTRA} state_t;

    state_t             state_q, state_d;
    logic [0:15][31:0]  buf_q, buf_d;
    logic [63:0]        len_q, len_d;
    logic [3:0]         widx_q, widx_d;
    logic               last_q, last_d;
    logic               extra_q, extra_d;
    logic               pend_q, pend_d;

    logic [2:0]         nbytes;
    logic [63:0]        len_new;
    logic [31:0]        mask;
    logic [31:0]        marker;
    logic [6:0]         pos;

    // Ready is forced low while reset is held, high in FILL otherwise.
    assign bus.oMsgReady   = iReset_n && (state_q == S_FILL);
    assign bus.oBlockValid = (state_q == S_OUT);
    assign bus.oLastBlock  = (state_q == S_OUT) && last_q;
    assign bus.oBlock      = (state_q == S_OUT) ? buf_q : '0;

    // State and datapath registers.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= S_FILL;
            buf_q   <= '0;
            len_q   <= '0;
            widx_q  <= '0;
            last_q  <= 1'b0;
            extra_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            last_q  <= last_d;
            extra_q <= extra_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state: word packing, final-word padding, length-only block.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        widx_d  = widx_q;
        last_d  = last_q;
        extra_d = extra_q;
        pend_d  = pend_q;

        nbytes  = bus.iMsgLast ? bus.iMsgBytes : 3'd4;
        len_new = len_q + {58'd0, nbytes, 3'b000};
        pos     = {1'b0, widx_q, 2'b00} + {4'd0, nbytes};

        case (nbytes)
            3'd0:    mask = 32'h0000_0000;
            3'd1:    mask = 32'hFF00_0000;
            3'd2:    mask = 32'hFFFF_0000;
            3'd3:    mask = 32'hFFFF_FF00;
            default: mask = 32'hFFFF_FFFF;
        endcase
        marker = (nbytes < 3'd4) ? (32'h8000_0000 >> {nbytes, 3'b000})
                                 : 32'h0;

        case (state_q)
            S_FILL: begin
                if (bus.iMsgValid) begin
                    len_d = len_new;
                    if (!bus.iMsgLast) begin
                        buf_d[widx_q] = bus.iMsgData;
                        if (widx_q == 4'd15) begin
                            widx_d  = 4'd0;
                            last_d  = 1'b0;
                            extra_d = 1'b0;
                            state_d = S_OUT;
                        end else begin
                            widx_d = widx_q + 4'd1;
                        end
                    end else begin
                        buf_d[widx_q] = (bus.iMsgData & mask) | marker;
                        for (int j = 0; j < 16; j++) begin
                            if (4'(j) > widx_q) begin
                                if (4'(j) == widx_q + 4'd1 && nbytes == 3'd4)
                                    buf_d[j] = 32'h8000_0000;
                                else
                                    buf_d[j] = 32'h0;
                            end
                        end
                        if (pos <= 7'd55) begin
                            buf_d[14] = len_new[63:32];
                            buf_d[15] = len_new[31:0];
                            last_d    = 1'b1;
                            extra_d   = 1'b0;
                        end else begin
                            last_d  = 1'b0;
                            extra_d = 1'b1;
                            pend_d  = (nbytes == 3'd4) && (widx_q == 4'd15);
                        end
                        widx_d  = 4'd0;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (bus.iBlockReady) begin
                    if (last_q) begin
                        state_d = S_FILL;
                        len_d   = '0;
                        widx_d  = '0;
                        last_d  = 1'b0;
                        extra_d = 1'b0;
                        pend_d  = 1'b0;
                    end else if (extra_q) begin
                        state_d = S_EXTRA;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_EXTRA: begin
                for (int j = 0; j < 14; j++) buf_d[j] = 32'h0;
                if (pend_q) buf_d[0] = 32'h8000_0000;
                buf_d[14] = len_q[63:32];
                buf_d[15] = len_q[31:0];
                last_d    = 1'b1;
                extra_d   = 1'b0;
                state_d   = S_OUT;
            end
            default: state_d = S_FILL;
        endcase
    end
endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: directed messages, queued
// expected blocks, negedge monitor comparing each block transfer.
module tb_sha256_padder;
    logic iClk = 1'b0;
    logic iReset_n = 1'b0;

    // Free-running clock, 10 time-unit period.
    always #5 iClk = ~iClk;

    sha256_padder_if bus();

    sha256_padder dut (
        .iClk(iClk),
        .iReset_n(iReset_n),
        .bus(bus)
    );

    typedef struct {
        logic [511:0] blk;
        logic         last;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [31:0] ew [16];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_blk = 0;

    task automatic check(input string nm, input logic [511:0] act,
                         input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dw(input int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    task automatic clear_ew();
        for (int i = 0; i < 16; i++) ew[i] = 32'h0;
    endtask

    task automatic push_exp(input logic last);
        exp_t e;
        e.blk = '0;
        for (int i = 0; i < 16; i++) e.blk[511-32*i -: 32] = ew[i];
        e.last = last;
        q.push_back(e);
        clear_ew();
    endtask

    // Called just after a posedge; returns just after the accept edge.
    task automatic send_word(input logic [31:0] d, input logic l,
                             input logic [2:0] b);
        logic ok;
        bus.iMsgData  = d;
        bus.iMsgLast  = l;
        bus.iMsgBytes = b;
        bus.iMsgValid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge iClk);
            ok = bus.oMsgReady;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL word_timeout: got ready=0 want ready=1");
        end
        @(posedge iClk);
        #1;
        bus.iMsgValid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge iClk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_drain: got %0d pending want 0", nm, q.size());
        end
        @(posedge iClk);
        #1;
    endtask

    // Monitor: every negedge with valid&&ready is one block transfer.
    always @(negedge iClk) begin
        if (iReset_n && bus.oBlockValid && bus.iBlockReady) begin
            n_blk++;
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_block%0d: got %h want none",
                         n_blk, bus.oBlock);
            end else begin
                me = q.pop_front();
                check($sformatf("blk%0d_data", n_blk), bus.oBlock, me.blk);
                check($sformatf("blk%0d_last", n_blk),
                      {511'd0, bus.oLastBlock}, {511'd0, me.last});
            end
        end
    end

    initial begin
        logic [511:0] held;
        bus.iMsgValid   = 1'b0;
        bus.iMsgData    = 32'h0;
        bus.iMsgLast    = 1'b0;
        bus.iMsgBytes   = 3'd0;
        bus.iBlockReady = 1'b1;
        clear_ew();

        #22;
        check("rst_ready", {511'd0, bus.oMsgReady}, 512'd0);
        check("rst_valid", {511'd0, bus.oBlockValid}, 512'd0);
        check("rst_last", {511'd0, bus.oLastBlock}, 512'd0);
        check("rst_block", bus.oBlock, 512'd0);
        iReset_n = 1'b1;
        #1;
        check("post_rst_ready", {511'd0, bus.oMsgReady}, 512'd1);
        @(posedge iClk);
        #1;

        // "abc"
        ew[0] = 32'h6162_6380;
        ew[15] = 32'h0000_0018;
        push_exp(1'b1);
        send_word(32'h6162_6300, 1'b1, 3'd3);

        // empty message; data bits must be masked off
        ew[0] = 32'h8000_0000;
        push_exp(1'b1);
        send_word(32'hDEAD_BEEF, 1'b1, 3'd0);

        // 55 bytes
        for (int i = 0; i < 13; i++) ew[i] = dw(i);
        ew[13] = 32'hAABB_CC80;
        ew[15] = 32'h0000_01B8;
        push_exp(1'b1);
        for (int i = 0; i < 13; i++) send_word(dw(i), 1'b0, 3'd4);
        send_word(32'hAABB_CCDD, 1'b1, 3'd3);

        // 56 bytes
        for (int i = 0; i < 14; i++) ew[i] = dw(i);
        ew[14] = 32'h8000_0000;
        push_exp(1'b0);
        ew[15] = 32'h0000_01C0;
        push_exp(1'b1);
        for (int i = 0; i < 13; i++) send_word(dw(i), 1'b0, 3'd4);
        send_word(dw(13), 1'b1, 3'd4);

        // 64 bytes, with EXTRA gap timing
        wait_drain("m56");
        for (int i = 0; i < 16; i++) ew[i] = dw(i);
        push_exp(1'b0);
        ew[0] = 32'h8000_0000;
        ew[15] = 32'h0000_0200;
        push_exp(1'b1);
        for (int i = 0; i < 15; i++) send_word(dw(i), 1'b0, 3'd4);
        send_word(dw(15), 1'b1, 3'd4);
        @(negedge iClk);
        check("gap_pre_valid", {511'd0, bus.oBlockValid}, 512'd1);
        @(negedge iClk);
        check("gap_extra_valid", {511'd0, bus.oBlockValid}, 512'd0);
        @(negedge iClk);
        check("gap_post_valid", {511'd0, bus.oBlockValid}, 512'd1);

        // backpressure with ignored input during OUT
        wait_drain("m64");
        bus.iBlockReady = 1'b0;
        for (int i = 0; i < 16; i++) ew[i] = dw(i + 32);
        held = '0;
        for (int i = 0; i < 16; i++) held[511-32*i -: 32] = ew[i];
        push_exp(1'b0);
        ew[0] = 32'h1234_8000;
        ew[15] = 32'h0000_0210;
        push_exp(1'b1);
        for (int i = 0; i < 16; i++) send_word(dw(i + 32), 1'b0, 3'd4);
        bus.iMsgValid = 1'b1;
        bus.iMsgData  = 32'hFFFF_FFFF;
        bus.iMsgLast  = 1'b1;
        bus.iMsgBytes = 3'd4;
        for (int c = 0; c < 5; c++) begin
            @(negedge iClk);
            check($sformatf("hold%0d_valid", c),
                  {511'd0, bus.oBlockValid}, 512'd1);
            check($sformatf("hold%0d_ready", c),
                  {511'd0, bus.oMsgReady}, 512'd0);
            check($sformatf("hold%0d_block", c), bus.oBlock, held);
        end
        @(posedge iClk);
        #1;
        bus.iMsgValid   = 1'b0;
        bus.iBlockReady = 1'b1;
        send_word(32'h1234_5678, 1'b1, 3'd2);

        // reset while a block is held
        wait_drain("bp");
        bus.iBlockReady = 1'b0;
        for (int i = 0; i < 16; i++) send_word(dw(i + 64), 1'b0, 3'd4);
        #1;
        iReset_n = 1'b0;
        #1;
        check("midrst_valid", {511'd0, bus.oBlockValid}, 512'd0);
        check("midrst_ready", {511'd0, bus.oMsgReady}, 512'd0);
        check("midrst_block", bus.oBlock, 512'd0);
        check("midrst_last", {511'd0, bus.oLastBlock}, 512'd0);
        @(negedge iClk);
        iReset_n = 1'b1;
        bus.iBlockReady = 1'b1;
        @(posedge iClk);
        #1;
        ew[0] = 32'h6162_6380;
        ew[15] = 32'h0000_0018;
        push_exp(1'b1);
        send_word(32'h6162_6300, 1'b1, 3'd3);

        wait_drain("final");
        repeat (3) @(posedge iClk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream message-formatting stage for the SHA-256 core. Accepts a byte-granular message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. It emits complete 512-bit blocks with a last-block flag over a valid/ready handshake. Its block output maps directly onto the core's block/last_block inputs; the integrating controller pulses the core's start on each output handshake.

## Interface
Parameters: none.

Ports:
- iClk  in  1  clock; all state changes on the rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iMsgValid  in  1  input word valid.
- oMsgReady  out  1  padder accepts a word this cycle.
- iMsgData  in  32  message word; first message byte in [31:24].
- iMsgLast  in  1  word is the final word of the message.
- iMsgBytes  in  3  valid bytes in the final word, 0..4, MSB-aligned. Ignored (treated as 4) when iMsgLast=0. 0 only for an empty message.
- oBlock  out  512  padded block; word 0 (first received) in [511:480], word 15 in [31:0].
- oBlockValid  out  1  oBlock/oLastBlock valid.
- iBlockReady  in  1  consumer takes the block.
- oLastBlock  out  1  block is the final block of the message.

## Operation
- A word transfer occurs when iMsgValid && oMsgReady. A block transfer occurs when oBlockValid && iBlockReady.
- States:
  - FILL: oMsgReady=1; receives words.
  - OUT: holds a block.
  - EXTRA: builds a length-only block.
- Word index widx runs 0..15. Each accepted word is written to buffer word widx.
- lenbits (64-bit) adds 8×bytes per accepted word. It wraps modulo 2^64; messages ≥ 2^61 bytes are unsupported.
- Non-final word:
  - widx < 15: increment widx.
  - widx = 15: go to OUT with last=0, widx←0.
- Final word with b valid bytes at index k:
  - Bytes beyond b are forced to 0.
  - Byte offset p = 4k+b within the block.
  - If b<4, 0x80 goes at byte p of word k. If b=4 and k<15, 0x80000000 goes in word k+1. If b=4 and k=15, a marker-pending flag is set.
  - All words after the marker are zeroed.
  - If p ≤ 55: words 14..15 ← final lenbits, last=1, go to OUT.
  - Else: last=0, go to OUT, then EXTRA.
- EXTRA (entered after the non-last block is accepted):
  - Buffer words 0..13 are zero, except word 0 = 0x80000000 if marker-pending.
  - Words 14..15 ← lenbits, last=1.
  - Go to OUT in the next cycle.
- OUT:
  - oBlockValid=1. oBlock and oLastBlock are held stable until transfer.
  - On transfer: if this was a final block, go to FILL, clearing lenbits, widx and flags. If it was a non-last block of an unfinished message, go to FILL. If the message was finished but needs a length block, go to EXTRA.
- Buffer words not yet written in FILL are don't-care; only completed blocks are visible on oBlock.

## Timing
- Reset values: oMsgReady=0 during reset, then 1 from the first cycle after release (state FILL). oBlockValid=0, oLastBlock=0, oBlock=0, lenbits=0, widx=0.
- Latency: word transfer completing a block at edge N → oBlockValid=1 after edge N. oBlockValid is registered with no combinational path from iBlockReady.
- oMsgReady=0 while in OUT or EXTRA. There are no back-to-back block and word transfers in the same cycle.
- EXTRA costs exactly 1 cycle between the first block's transfer and the second block's oBlockValid.
- Minimum period per 16-word block is 17 cycles (16 accept + 1 OUT, with iBlockReady=1).
- Reset asserted mid-message or mid-OUT discards everything: outputs return to reset values immediately (asynchronously) and the partial message is lost.
- iMsgValid is sampled only in FILL. Input changes while oMsgReady=0 have no effect.

## Test plan
- "abc" (one word 0x61626300, last, bytes=3) → one block: word0=0x61626380, words1..14=0, word15=0x00000018, oLastBlock=1. Feeding it to the core gives digest ba7816bf…f20015ad.
- Empty message (last, bytes=0) → one block: word0=0x80000000, all other words 0, oLastBlock=1.
- 55-byte message (14 words, last bytes=3) → single block: word13 ends with 0x80, word14=0, word15=0x000001B8, last=1.
- 56-byte message (14 full words, last bytes=4) → block1: words0..13 data, word14=0x80000000, word15=0, last=0. Then block2: words0..13=0, word15=0x000001C0, last=1.
- 64-byte message (16 full words) → block1 = data, last=0. Block2: word0=0x80000000, word15=0x00000200, last=1. Check the 1-cycle EXTRA gap.
- Backpressure: hold iBlockReady=0 for 5 cycles with oBlockValid=1 → oBlock stable, oMsgReady=0, no words lost. Also assert iReset_n=0 mid-message → oBlockValid=0 and the next message pads from lenbits=0.
